clic_irq_arbiter: RTL and testbench

- Sits between the per-source CLIC interrupt registers (ip/ie/attr/ctl) and the core-side CLIC interface.
- Selects the single highest-priority pending and enabled source and drives the valid/ready handshake (valid, id, level, shv, priv) towards the core interface.
- On acceptance, issues a one-cycle claim pulse to the winning source so edge-triggered pending bits are cleared.

---
 rtl/clic_irq_arbiter_pkg.sv | 45 ++++
 rtl/clic_max_tree.sv | 67 ++++++
 rtl/clic_irq_arbiter.sv | 164 ++++++++++++++++
 tb/tb_clic_irq_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clic_irq_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// clic_irq_arbiter_pkg
// Shared types and helpers for the CLIC interrupt arbiter slice.
//   mode_t      : privilege mode encodings (M/S/U) used for the priv compare
//   arb_state_e : arbiter handshake FSM states
//   prio_key_t  : 10-bit priority key {rank(priv), level}, compared unsigned
//   priv_rank   : maps a raw privilege field onto its 2-bit rank
//   priv_out    : maps a raw privilege field onto the value driven to the core
// ---------------------------------------------------------------------------
package clic_irq_arbiter_pkg;

    typedef enum logic [1:0] {
        U_MODE = 2'b00,
        S_MODE = 2'b01,
        M_MODE = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [1:0] rank;
        logic [7:0] level;
    } prio_key_t;

    // The reserved encoding 2'b10 ranks alongside user mode.
    function automatic logic [1:0] priv_rank(input logic [1:0] priv);
        logic [1:0] rank;
        case (priv)
            M_MODE:  rank = 2'd2;
            S_MODE:  rank = 2'd1;
            default: rank = 2'd0;
        endcase
        return rank;
    endfunction

    // The reserved encoding is never forwarded; the core sees it as user mode.
    function automatic logic [1:0] priv_out(input logic [1:0] priv);
        return (priv == 2'b10) ? U_MODE : priv;
    endfunction

endpackage

// File: rtl/clic_max_tree.sv
// ---------------------------------------------------------------------------
// clic_max_tree
// Combinational binary max tree. Finds the highest key among the valid leaves;
// on equal keys the leaf with the higher index wins.
// Ports:
//   valid_i     [N]      : leaf valid
//   key_i       [N]      : leaf priority key (unpacked array)
//   any_valid_o          : at least one leaf is valid
//   win_id_o    [ID_W]   : index of the winning leaf
//   win_key_o            : key of the winning leaf
// ---------------------------------------------------------------------------
module clic_max_tree
    import clic_irq_arbiter_pkg::*;
#(
    parameter  int N    = 256,
    localparam int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    valid_i,
    input  prio_key_t       key_i [N],
    output logic            any_valid_o,
    output logic [ID_W-1:0] win_id_o,
    output prio_key_t       win_key_o
);

    localparam int LEAVES = 1 << ID_W;
    localparam int NODES  = 2 * LEAVES - 1;

    logic            nodeValid [NODES];
    logic [ID_W-1:0] nodeId    [NODES];
    prio_key_t       nodeKey   [NODES];

    // Heap-ordered tree: node n has children 2n+1 (lower indices) and 2n+2
    // (higher indices), leaves start at LEAVES-1. Padding leaves beyond N
    // stay invalid. The right child wins ties so the higher ID is preferred.
    always_comb begin
        for (int n = 0; n < NODES; n++) begin
            nodeValid[n] = 1'b0;
            nodeId[n]    = '0;
            nodeKey[n]   = '0;
        end
        for (int i = 0; i < N; i++) begin
            nodeValid[LEAVES-1+i] = valid_i[i];
            nodeId[LEAVES-1+i]    = ID_W'(i);
            nodeKey[LEAVES-1+i]   = key_i[i];
        end
        for (int n = LEAVES - 2; n >= 0; n--) begin
            if (nodeValid[2*n+2] &&
                (!nodeValid[2*n+1] || (nodeKey[2*n+2] >= nodeKey[2*n+1]))) begin
                nodeValid[n] = 1'b1;
                nodeId[n]    = nodeId[2*n+2];
                nodeKey[n]   = nodeKey[2*n+2];
            end else begin
                nodeValid[n] = nodeValid[2*n+1];
                nodeId[n]    = nodeId[2*n+1];
                nodeKey[n]   = nodeKey[2*n+1];
            end
        end
    end

    // The root of the tree is the overall winner.
    always_comb begin
        any_valid_o = nodeValid[0];
        win_id_o    = nodeId[0];
        win_key_o   = nodeKey[0];
    end

endmodule

// File: rtl/clic_irq_arbiter.sv
// ---------------------------------------------------------------------------
// clic_irq_arbiter
// Picks the highest-priority pending and enabled CLIC source, presents it to
// the core interface through a valid/ready handshake and, once accepted,
// pulses claim_o for one cycle so edge-triggered pending bits get cleared.
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   ip_i, ie_i             : per-source pending / enable
//   shv_i                  : per-source selective hardware vectoring
//   priv_i                 : per-source privilege, source k at [2k+1:2k]
//   level_i                : per-source level, source k at [8k+7:8k]
//   clic_irq_valid_o       : request valid towards the core
//   clic_irq_ready_i       : core acknowledges the request
//   clic_irq_id_o/level_o/shv_o/priv_o : registered winner data
//   claim_o                : one-hot claim pulse to the accepted source
// Optional feature macro: CLIC_ARB_PREEMPT_EN -- a strictly higher key
// arriving while a request is outstanding and unacknowledged displaces it.
// ---------------------------------------------------------------------------
module clic_irq_arbiter
    import clic_irq_arbiter_pkg::*;
#(
    parameter  int N_SOURCE   = 256,
    parameter  int INTCTLBITS = 8,
    localparam int SRC_W      = $clog2(N_SOURCE)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [N_SOURCE-1:0]   ip_i,
    input  logic [N_SOURCE-1:0]   ie_i,
    input  logic [N_SOURCE-1:0]   shv_i,
    input  logic [2*N_SOURCE-1:0] priv_i,
    input  logic [8*N_SOURCE-1:0] level_i,
    output logic                  clic_irq_valid_o,
    input  logic                  clic_irq_ready_i,
    output logic [SRC_W-1:0]      clic_irq_id_o,
    output logic [7:0]            clic_irq_level_o,
    output logic                  clic_irq_shv_o,
    output logic [1:0]            clic_irq_priv_o,
    output logic [N_SOURCE-1:0]   claim_o
);

    // Unimplemented low level bits read as ones.
    localparam logic [7:0] LEVEL_FILL = 8'(8'hFF >> INTCTLBITS);

    logic [N_SOURCE-1:0] cand;
    prio_key_t           leafKey [N_SOURCE];
    logic                anyValid;
    logic [SRC_W-1:0]    winId;
    prio_key_t           winKey;
    logic [1:0]          winPriv;

    arb_state_e          state_q;
    logic                valid_q;
    logic [SRC_W-1:0]    id_q;
    logic [7:0]          level_q;
    logic                shv_q;
    logic [1:0]          priv_q;
    logic [N_SOURCE-1:0] claim_q;

    // Build the per-source candidate vector and priority keys. Levels are
    // masked before comparison so sources differing only in unimplemented
    // bits tie and fall back to the ID rule.
    always_comb begin
        cand = ip_i & ie_i;
        for (int k = 0; k < N_SOURCE; k++) begin
            leafKey[k].rank  = priv_rank(priv_i[2*k +: 2]);
            leafKey[k].level = level_i[8*k +: 8] | LEVEL_FILL;
        end
    end

    clic_max_tree #(
        .N (N_SOURCE)
    ) u_max_tree (
        .valid_i     (cand),
        .key_i       (leafKey),
        .any_valid_o (anyValid),
        .win_id_o    (winId),
        .win_key_o   (winKey)
    );

    // Raw privilege of the current winner, looked up by its ID.
    always_comb begin
        winPriv = priv_i[{winId, 1'b0} +: 2];
    end

`ifdef CLIC_ARB_PREEMPT_EN
    prio_key_t key_q;

    // Key of the outstanding request, kept only for the preemption compare.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            key_q <= '0;
        end else if (state_q == IDLE && anyValid) begin
            key_q <= winKey;
        end
    end
`else
    logic unusedWinRank;
    assign unusedWinRank = ^winKey.rank;
`endif

    // Handshake FSM with all outputs registered. IDLE captures the winner,
    // REQ holds it until acceptance or withdrawal (ready wins a tie with
    // withdrawal), ACK emits the claim pulse. Data registers are left alone
    // outside of capture so they keep their last value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            id_q    <= '0;
            level_q <= '0;
            shv_q   <= 1'b0;
            priv_q  <= '0;
            claim_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    claim_q <= '0;
                    if (anyValid) begin
                        state_q <= REQ;
                        valid_q <= 1'b1;
                        id_q    <= winId;
                        level_q <= winKey.level;
                        shv_q   <= shv_i[winId];
                        priv_q  <= priv_out(winPriv);
                    end
                end
                REQ: begin
                    if (clic_irq_ready_i) begin
                        state_q <= ACK;
                        valid_q <= 1'b0;
                        claim_q <= N_SOURCE'(1) << id_q;
                    end else if (!cand[id_q]) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
`ifdef CLIC_ARB_PREEMPT_EN
                    end else if (anyValid && (winKey > key_q)) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
`endif
                    end
                end
                ACK: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    claim_q <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    claim_q <= '0;
                end
            endcase
        end
    end

    assign clic_irq_valid_o = valid_q;
    assign clic_irq_id_o    = id_q;
    assign clic_irq_level_o = level_q;
    assign clic_irq_shv_o   = shv_q;
    assign clic_irq_priv_o  = priv_q;
    assign claim_o          = claim_q;

endmodule

// File: tb/tb_clic_irq_arbiter.sv
// ---------------------------------------------------------------------------
// tb_clic_irq_arbiter
// Directed bench for clic_irq_arbiter with 16 sources. dut drives the full
// 8 level bits, dut3 implements only 3 level bits. Each source has a fixed
// priv/level/shv configuration; a vector table drives ip/ie/ready cycle by
// cycle, followed by hand-written sequences for withdrawal, preemption,
// equal-key hold, reset mid-handshake and level masking.
// ---------------------------------------------------------------------------
module tb_clic_irq_arbiter;

   localparam int NS = 16;

   logic            clk;
   logic            rstN;
   logic [NS-1:0]   ip;
   logic [NS-1:0]   ie;
   logic [NS-1:0]   shv;
   logic [2*NS-1:0] priv;
   logic [8*NS-1:0] level;
   logic            ready;
   logic            valid;
   logic [3:0]      irqId;
   logic [7:0]      irqLevel;
   logic            irqShv;
   logic [1:0]      irqPriv;
   logic [NS-1:0]   claim;

   logic [NS-1:0]   ip3;
   logic            ready3;
   logic            valid3;
   logic [3:0]      irqId3;
   logic [7:0]      irqLevel3;
   logic            irqShv3;
   logic [1:0]      irqPriv3;
   logic [NS-1:0]   claim3;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] ip;
      logic [15:0] ie;
      logic        rdy;
      logic        eValid;
      logic [3:0]  eId;
      logic [7:0]  eLevel;
      logic        eShv;
      logic [1:0]  ePriv;
      logic [15:0] eClaim;
   } vec_t;

   vec_t vecs [$];

   clic_irq_arbiter #(
      .N_SOURCE   (NS),
      .INTCTLBITS (8)
   ) dut (
      .clk_i            (clk),
      .rst_ni           (rstN),
      .ip_i             (ip),
      .ie_i             (ie),
      .shv_i            (shv),
      .priv_i           (priv),
      .level_i          (level),
      .clic_irq_valid_o (valid),
      .clic_irq_ready_i (ready),
      .clic_irq_id_o    (irqId),
      .clic_irq_level_o (irqLevel),
      .clic_irq_shv_o   (irqShv),
      .clic_irq_priv_o  (irqPriv),
      .claim_o          (claim)
   );

   clic_irq_arbiter #(
      .N_SOURCE   (NS),
      .INTCTLBITS (3)
   ) dut3 (
      .clk_i            (clk),
      .rst_ni           (rstN),
      .ip_i             (ip3),
      .ie_i             (16'hFFFF),
      .shv_i            (shv),
      .priv_i           (priv),
      .level_i          (level),
      .clic_irq_valid_o (valid3),
      .clic_irq_ready_i (ready3),
      .clic_irq_id_o    (irqId3),
      .clic_irq_level_o (irqLevel3),
      .clic_irq_shv_o   (irqShv3),
      .clic_irq_priv_o  (irqPriv3),
      .claim_o          (claim3)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      ip    = v.ip;
      ie    = v.ie;
      ready = v.rdy;
   endtask

   task automatic checkRow(input string tag, input vec_t v);
      checkOutput({tag, ".valid"}, 32'(valid), 32'(v.eValid));
      checkOutput({tag, ".id"},    32'(irqId), 32'(v.eId));
      checkOutput({tag, ".level"}, 32'(irqLevel), 32'(v.eLevel));
      checkOutput({tag, ".shv"},   32'(irqShv), 32'(v.eShv));
      checkOutput({tag, ".priv"},  32'(irqPriv), 32'(v.ePriv));
      checkOutput({tag, ".claim"}, 32'(claim), 32'(v.eClaim));
   endtask

   task automatic checkVC(input string tag, input logic eValid, input logic [3:0] eId, input logic [15:0] eClaim);
      checkOutput({tag, ".valid"}, 32'(valid), 32'(eValid));
      if (eValid) checkOutput({tag, ".id"}, 32'(irqId), 32'(eId));
      checkOutput({tag, ".claim"}, 32'(claim), 32'(eClaim));
   endtask

   // Fixed per-source configuration: {priv, level, shv}.
   task automatic configureSources();
      logic [1:0] cp [NS];
      logic [7:0] cl [NS];
      logic       cs [NS];
      for (int k = 0; k < NS; k++) begin
         cp[k] = 2'b00; cl[k] = 8'h00; cs[k] = 1'b0;
      end
      cp[1]  = 2'b00; cl[1]  = 8'h30; cs[1]  = 1'b0;
      cp[2]  = 2'b11; cl[2]  = 8'h20; cs[2]  = 1'b1;
      cp[3]  = 2'b11; cl[3]  = 8'h40; cs[3]  = 1'b0;
      cp[4]  = 2'b01; cl[4]  = 8'h50; cs[4]  = 1'b1;
      cp[5]  = 2'b01; cl[5]  = 8'h80; cs[5]  = 1'b0;
      cp[6]  = 2'b11; cl[6]  = 8'h90; cs[6]  = 1'b1;
      cp[7]  = 2'b11; cl[7]  = 8'h40; cs[7]  = 1'b1;
      cp[8]  = 2'b10; cl[8]  = 8'hF0; cs[8]  = 1'b0;
      cp[9]  = 2'b11; cl[9]  = 8'h10; cs[9]  = 1'b1;
      cp[10] = 2'b00; cl[10] = 8'hFF; cs[10] = 1'b0;
      cp[11] = 2'b00; cl[11] = 8'h30; cs[11] = 1'b0;
      cp[12] = 2'b01; cl[12] = 8'h50; cs[12] = 1'b0;
      for (int k = 0; k < NS; k++) begin
         priv[2*k +: 2]  = cp[k];
         level[8*k +: 8] = cl[k];
         shv[k]          = cs[k];
      end
   endtask

   // Cycle-by-cycle vectors: inputs driven in a cycle, outputs expected
   // after the following clock edge.
   task automatic buildVectors();
      // Test 2: S 0x80 vs M 0x10 -> M wins; ready after three valid cycles
      vecs.push_back('{16'h0220, 16'hFFFF, 1'b0, 1'b1, 4'd9,  8'h10, 1'b1, 2'b11, 16'h0000});
      vecs.push_back('{16'h0220, 16'hFFFF, 1'b0, 1'b1, 4'd9,  8'h10, 1'b1, 2'b11, 16'h0000});
      vecs.push_back('{16'h0220, 16'hFFFF, 1'b0, 1'b1, 4'd9,  8'h10, 1'b1, 2'b11, 16'h0000});
      vecs.push_back('{16'h0220, 16'hFFFF, 1'b1, 1'b0, 4'd9,  8'h10, 1'b1, 2'b11, 16'h0200});
      vecs.push_back('{16'h0020, 16'hFFFF, 1'b0, 1'b0, 4'd9,  8'h10, 1'b1, 2'b11, 16'h0000});
      vecs.push_back('{16'h0020, 16'hFFFF, 1'b0, 1'b1, 4'd5,  8'h80, 1'b0, 2'b01, 16'h0000});
      vecs.push_back('{16'h0020, 16'hFFFF, 1'b1, 1'b0, 4'd5,  8'h80, 1'b0, 2'b01, 16'h0020});
      vecs.push_back('{16'h0000, 16'hFFFF, 1'b0, 1'b0, 4'd5,  8'h80, 1'b0, 2'b01, 16'h0000});
      // Test 3: equal keys -> higher ID, then the lower one at claim+2
      vecs.push_back('{16'h0088, 16'hFFFF, 1'b0, 1'b1, 4'd7,  8'h40, 1'b1, 2'b11, 16'h0000});
      vecs.push_back('{16'h0088, 16'hFFFF, 1'b1, 1'b0, 4'd7,  8'h40, 1'b1, 2'b11, 16'h0080});
      vecs.push_back('{16'h0008, 16'hFFFF, 1'b0, 1'b0, 4'd7,  8'h40, 1'b1, 2'b11, 16'h0000});
      vecs.push_back('{16'h0008, 16'hFFFF, 1'b0, 1'b1, 4'd3,  8'h40, 1'b0, 2'b11, 16'h0000});
      vecs.push_back('{16'h0008, 16'hFFFF, 1'b1, 1'b0, 4'd3,  8'h40, 1'b0, 2'b11, 16'h0008});
      vecs.push_back('{16'h0000, 16'hFFFF, 1'b0, 1'b0, 4'd3,  8'h40, 1'b0, 2'b11, 16'h0000});
      // Reserved priv ranks as U and is output as U
      vecs.push_back('{16'h0902, 16'hFFFF, 1'b0, 1'b1, 4'd8,  8'hF0, 1'b0, 2'b00, 16'h0000});
      vecs.push_back('{16'h0902, 16'hFFFF, 1'b1, 1'b0, 4'd8,  8'hF0, 1'b0, 2'b00, 16'h0100});
      // U tie (1 vs 11) and S tie (4 vs 12) -> higher ID
      vecs.push_back('{16'h0802, 16'hFFFF, 1'b0, 1'b0, 4'd8,  8'hF0, 1'b0, 2'b00, 16'h0000});
      vecs.push_back('{16'h0802, 16'hFFFF, 1'b0, 1'b1, 4'd11, 8'h30, 1'b0, 2'b00, 16'h0000});
      vecs.push_back('{16'h0802, 16'hFFFF, 1'b1, 1'b0, 4'd11, 8'h30, 1'b0, 2'b00, 16'h0800});
      vecs.push_back('{16'h1010, 16'hFFFF, 1'b0, 1'b0, 4'd11, 8'h30, 1'b0, 2'b00, 16'h0000});
      vecs.push_back('{16'h1010, 16'hFFFF, 1'b0, 1'b1, 4'd12, 8'h50, 1'b0, 2'b01, 16'h0000});
      vecs.push_back('{16'h1010, 16'hFFFF, 1'b1, 1'b0, 4'd12, 8'h50, 1'b0, 2'b01, 16'h1000});
      // Pending but disabled is not a candidate
      vecs.push_back('{16'h0010, 16'hFFEF, 1'b0, 1'b0, 4'd12, 8'h50, 1'b0, 2'b01, 16'h0000});
      vecs.push_back('{16'h0010, 16'hFFEF, 1'b0, 1'b0, 4'd12, 8'h50, 1'b0, 2'b01, 16'h0000});
      // S 0x50 beats U 0xFF
      vecs.push_back('{16'h0410, 16'hFFFF, 1'b0, 1'b1, 4'd4,  8'h50, 1'b1, 2'b01, 16'h0000});
      vecs.push_back('{16'h0410, 16'hFFFF, 1'b1, 1'b0, 4'd4,  8'h50, 1'b1, 2'b01, 16'h0010});
      vecs.push_back('{16'h0000, 16'hFFFF, 1'b0, 1'b0, 4'd4,  8'h50, 1'b1, 2'b01, 16'h0000});
   endtask

   initial begin
      rstN   = 1'b0;
      ip     = '0;
      ie     = '1;
      ready  = 1'b0;
      ip3    = '0;
      ready3 = 1'b0;
      configureSources();
      buildVectors();

      // Reset state
      step();
      step();
      checkVC("reset", 1'b0, 4'd0, 16'h0000);
      checkOutput("reset.id", 32'(irqId), 32'd0);
      checkOutput("reset.level", 32'(irqLevel), 32'd0);
      checkOutput("reset3.valid", 32'(valid3), 32'd0);

      // Test 1: idle after reset release with nothing pending
      rstN = 1'b1;
      for (int c = 0; c < 20; c++) begin
         step();
         checkVC($sformatf("idle[%0d]", c), 1'b0, 4'd0, 16'h0000);
      end

      // Vector table
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         step();
         checkRow($sformatf("vec[%0d]", i), vecs[i]);
      end

      // Test 5: withdrawal via ie clear, then ready beating a withdrawal
      ip = 16'h0010; ie = 16'hFFFF; ready = 1'b0;
      step(); checkVC("wd.req", 1'b1, 4'd4, 16'h0000);
      ie = 16'hFFEF;
      step(); checkVC("wd.drop", 1'b0, 4'd0, 16'h0000);
      step(); checkVC("wd.idle", 1'b0, 4'd0, 16'h0000);
      ie = 16'hFFFF;
      step(); checkVC("wd.rereq", 1'b1, 4'd4, 16'h0000);
      ie = 16'hFFEF; ready = 1'b1;
      step(); checkVC("wd.readywins", 1'b0, 4'd0, 16'h0010);
      ip = '0; ie = 16'hFFFF; ready = 1'b0;
      step(); checkVC("wd.end", 1'b0, 4'd0, 16'h0000);

      // Equal key arriving never displaces the outstanding request
      ip = 16'h0080;
      step(); checkVC("eq.req", 1'b1, 4'd7, 16'h0000);
      ip = 16'h0088;
      step(); checkVC("eq.hold1", 1'b1, 4'd7, 16'h0000);
      step(); checkVC("eq.hold2", 1'b1, 4'd7, 16'h0000);
      ready = 1'b1;
      step(); checkVC("eq.claim", 1'b0, 4'd0, 16'h0080);
      ip = '0; ready = 1'b0;
      step(); checkVC("eq.end", 1'b0, 4'd0, 16'h0000);

      // Test 6: higher key arrives while source 2 is requesting
      ip = 16'h0004;
      step(); checkVC("pre.req", 1'b1, 4'd2, 16'h0000);
      ip = 16'h0044;
`ifdef CLIC_ARB_PREEMPT_EN
      step(); checkVC("pre.gap", 1'b0, 4'd0, 16'h0000);
      step(); checkVC("pre.new", 1'b1, 4'd6, 16'h0000);
      checkOutput("pre.level", 32'(irqLevel), 32'h90);
      ready = 1'b1;
      step(); checkVC("pre.claim", 1'b0, 4'd0, 16'h0040);
`else
      step(); checkVC("pre.hold1", 1'b1, 4'd2, 16'h0000);
      step(); checkVC("pre.hold2", 1'b1, 4'd2, 16'h0000);
      checkOutput("pre.level", 32'(irqLevel), 32'h20);
      ready = 1'b1;
      step(); checkVC("pre.claim", 1'b0, 4'd0, 16'h0004);
`endif
      ip = '0; ready = 1'b0;
      step(); checkVC("pre.end", 1'b0, 4'd0, 16'h0000);

      // Reset asserted mid-handshake: outputs clear, no claim issued
      ip = 16'h0200;
      step(); checkVC("rst.req", 1'b1, 4'd9, 16'h0000);
      ready = 1'b1;
      #2 rstN = 1'b0;
      #1;
      checkVC("rst.async", 1'b0, 4'd0, 16'h0000);
      checkOutput("rst.id", 32'(irqId), 32'd0);
      checkOutput("rst.priv", 32'(irqPriv), 32'd0);
      step(); checkVC("rst.held", 1'b0, 4'd0, 16'h0000);
      ip = '0; ready = 1'b0; rstN = 1'b1;
      step(); checkVC("rst.after", 1'b0, 4'd0, 16'h0000);

      // Test 4: only 3 level bits implemented, 0x40 reads back as 0x5F
      ip3 = 16'h0008;
      step();
      checkOutput("mask.valid", 32'(valid3), 32'd1);
      checkOutput("mask.id", 32'(irqId3), 32'd3);
      checkOutput("mask.level", 32'(irqLevel3), 32'h5F);
      checkOutput("mask.priv", 32'(irqPriv3), 32'h3);
      ready3 = 1'b1;
      step();
      checkOutput("mask.claim", 32'(claim3), 32'h0008);
      ip3 = '0; ready3 = 1'b0;
      step();
      checkOutput("mask.end", 32'(valid3), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
